// File: rtl/ud_counter_191_pkg.sv
// Shared constants for the ud_counter_191 up/down counter and its per-bit cell.
package ud_counter_191_pkg;

    // Direction encoding on the DU input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Width limits and default counter width.
    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned WIDTH_MIN     = 2;
    localparam int unsigned WIDTH_MAX     = 16;

endpackage

// File: rtl/ud_cell.sv
// One bit of the up/down counter: async-reset flop with load mux and toggle input.
module ud_cell (
    input  logic cp,
    input  logic rst,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    // Load wins over toggle; with neither, the bit holds.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    // Bit storage, cleared immediately by reset.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ud_counter_191.sv
// Synchronous presettable up/down counter with terminal-count, cascade and wrap outputs.
module ud_counter_191
    import ud_counter_191_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             LD,
    input  logic             EN,
    input  logic             DU,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QR,
    output logic             MAXMIN,
    output logic             TC,
    output logic             WRAP
);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("ud_counter_191: WIDTH out of range");
    end

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] match;
    logic [WIDTH-1:0] tgl;
    logic             at_max;
    logic             at_min;
    logic             maxmin;
    logic             tc;
    logic             wrap_q;

    // A bit "matches" when it lets a carry (up) or borrow (down) ripple past it.
    always_comb begin
        match = (DU == DIR_DOWN) ? ~count : count;
    end

    // Toggle chain: bit i flips when counting and every lower bit matches.
    always_comb begin
        logic run;
        tgl = '0;
        run = EN;
        for (int i = 0; i < WIDTH; i++) begin
            tgl[i] = run;
            run    = run & match[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ud_cell u_cell (
            .cp  (CP),
            .rst (RST),
            .ld  (LD),
            .d   (D[i]),
            .t   (tgl[i]),
            .q   (count[i])
        );
    end

    // Terminal-count detection follows DU combinationally.
    always_comb begin
        at_max = &count;
        at_min = ~|count;
        maxmin = (DU == DIR_DOWN) ? at_min : at_max;
        tc     = maxmin & EN & ~LD;
    end

    // A wrap happens exactly on an edge where the cascade output was high.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= tc;
        end
    end

    assign Q      = count;
    assign QR     = ~count;
    assign MAXMIN = maxmin;
    assign TC     = tc;
    assign WRAP   = wrap_q;

endmodule
